sha256_padder: RTL

- Front end that feeds the SHA-256 compression core.
- Accepts a message as a byte stream with valid/ready/last, and assembles big-endian 512-bit blocks.
- Applies FIPS 180-4 padding: 0x80, zero fill, then the 64-bit bit-length.
- Drives the core's start/block inputs and waits for the core's finish before issuing the next block.

---
 rtl/sha256_padder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
//
// Front end for a SHA-256 compression core. Collects a byte stream into
// big-endian 512-bit blocks, appends the standard padding (0x80, zero fill,
// 64-bit message bit length), and hands each block to the core with a
// one-cycle start pulse. The padder waits for the core's finish before it
// prepares or issues the next block.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   in_data      message byte
//   in_valid     in_data is valid
//   in_last      final byte of the message (qualified by in_valid)
//   in_ready     padder accepts a byte this cycle
//   core_block   512-bit block to the core, byte 0 at [511:504]
//   core_start   one-cycle pulse launching the core on core_block
//   core_first   with core_start: first block of a message
//   core_finish  core completed the current block (only looked at in WAIT)
//   msg_done     one-cycle pulse after the final block's core_finish
// -----------------------------------------------------------------------------
module sha256_padder #(
  parameter int BYTE_CNT_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] core_block,
  output logic         core_start,
  output logic         core_first,
  input  logic         core_finish,
  output logic         msg_done
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [5:0]            idx;            // next byte slot in the block
  logic [BYTE_CNT_W-1:0] count;          // message bytes accepted so far
  logic [511:0]          blk;            // block under construction / in flight
  logic                  final_blk;      // block in flight is the message's last
  logic                  pad_pending;    // message ended exactly on a block edge
  logic                  extra_pending;  // length did not fit; one more block due
  logic                  issued;         // a block of this message has been started

  logic                  xfer;
  logic [63:0]           bit_len;
  logic [511:0]          pad_blk;
  logic [511:0]          len_blk;

  assign xfer    = in_valid && in_ready;
  assign bit_len = 64'(count) << 3;
  assign len_blk = {448'b0, bit_len};

  // Padded view of the current buffer: bytes before idx kept, 0x80 at idx,
  // zeros after, and the bit length in the tail if it still fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pad_blk = '0;
    for (int j = 0; j < 64; j++) begin
      if (j < int'(idx)) begin
        pad_blk[511-8*j -: 8] = blk[511-8*j -: 8];
      end else if (j == int'(idx)) begin
        pad_blk[511-8*j -: 8] = 8'h80;
      end
    end
    if (idx <= 6'd55) begin
      pad_blk[63:0] = bit_len;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FILL: begin
        if (xfer) begin
          if (idx == 6'd63) begin
            state_nxt = S_SEND;
          end else if (in_last) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD:  state_nxt = S_SEND;
      S_SEND: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_finish) begin
          if (final_blk) begin
            state_nxt = S_DONE;
          end else if (pad_pending) begin
            state_nxt = S_PAD;
          end else if (extra_pending) begin
            state_nxt = S_SEND;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      S_DONE:  state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    core_first = 1'b0;
    msg_done   = 1'b0;
    unique case (state)
      S_FILL: in_ready = reset;  // state already reads FILL while reset is low
      S_SEND: begin
        core_start = 1'b1;
        core_first = !issued;
      end
      S_DONE:  msg_done = 1'b1;
      default: ;
    endcase
  end

  assign core_block = blk;

  // ---------------------------------------------------------------------------
  // Datapath: block buffer, byte index, counters and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the block buffer is reset on purpose because it drives core_block,
    // which must read zero out of reset; it is a register, not a RAM.
    if (!reset) begin
      blk           <= '0;
      idx           <= '0;
      count         <= '0;
      final_blk     <= 1'b0;
      pad_pending   <= 1'b0;
      extra_pending <= 1'b0;
      issued        <= 1'b0;
    end else begin
      unique case (state)
        S_FILL: begin
          if (xfer) begin
            blk[511-8*int'(idx) -: 8] <= in_data;
            idx                       <= idx + 6'd1;  // wraps to 0 after a full block
            if (count != '1) begin
              count <= count + BYTE_CNT_W'(1);
            end
            if (idx == 6'd63) begin
              final_blk   <= 1'b0;
              pad_pending <= in_last;
            end
          end
        end
        S_PAD: begin
          blk <= pad_blk;
          if (idx <= 6'd55) begin
            final_blk <= 1'b1;
          end else begin
            final_blk     <= 1'b0;
            extra_pending <= 1'b1;
          end
        end
        S_SEND: begin
          issued <= 1'b1;
        end
        S_WAIT: begin
          if (core_finish && !final_blk) begin
            if (pad_pending) begin
              // Next block is padding only: 0x80 at byte 0 plus the length.
              blk         <= '0;
              idx         <= '0;
              pad_pending <= 1'b0;
            end else if (extra_pending) begin
              blk           <= len_blk;
              final_blk     <= 1'b1;
              extra_pending <= 1'b0;
            end else begin
              blk <= '0;
              idx <= '0;
            end
          end
        end
        S_DONE: begin
          blk           <= '0;
          idx           <= '0;
          count         <= '0;
          final_blk     <= 1'b0;
          pad_pending   <= 1'b0;
          extra_pending <= 1'b0;
          issued        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
